// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO and status register.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          CLK_DIV   = 16,
  parameter int          FIFO_LOG  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_TOP = CW'(CLK_DIV - 1);
  localparam logic [FIFO_LOG:0] CNT_FULL = (FIFO_LOG+1)'(DEPTH);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          bitn;
  logic [7:0]          shreg;
`ifdef UART_TX_PARITY_EN
  logic                par;
`endif

  logic [7:0]          fifo_mem [DEPTH];
  logic [FIFO_LOG-1:0] wptr;
  logic [FIFO_LOG-1:0] rptr;
  logic [FIFO_LOG:0]   count;
  logic [FIFO_LOG:0]   count_nxt;
  logic [7:0]          head;

  logic push_req, clr_req, rd_req;
  logic empty, full, stop_end;
  logic pop, push, drop, idle_nxt;

  wire unused_ok = &{1'b0, mem_wmask[3:1],
                     mem_wdata[31:8]};

  assign push_req = mem_valid & mem_write
                  & mem_wmask[0]
                  & (mem_addr == BASE_ADDR);
  assign clr_req  = mem_valid & mem_write
                  & mem_wmask[0] & mem_wdata[0]
                  & (mem_addr == STAT_ADDR);
  assign rd_req   = mem_valid & ~mem_write
                  & (mem_addr == STAT_ADDR);

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign stop_end = (state == STOP) && (cnt == '0);
  assign pop      = !empty
                  && ((state == IDLE) || stop_end);
  // A full FIFO still accepts when a pop frees a slot this cycle
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign idle_nxt = ((state == IDLE) || stop_end)
                  && !pop;
  assign head     = fifo_mem[rptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (FIFO_LOG+1)'(1);
    else if (!push && pop)
      count_nxt = count - (FIFO_LOG+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + FIFO_LOG'(1);
      if (pop)
        rptr <= rptr + FIFO_LOG'(1);
      count <= count_nxt;
    end
  end

  // tx is registered from the current state, so it trails it by a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      busy <= !idle_nxt || (count_nxt != '0);
      if (pop) begin
        shreg <= head;
`ifdef UART_TX_PARITY_EN
        par   <= ^head;
`endif
      end
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state <= START;
            cnt   <= DIV_TOP;
          end
        end
        START: begin
          tx <= 1'b0;
          if (cnt == '0) begin
            state <= DATA;
            cnt   <= DIV_TOP;
            bitn  <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (cnt == '0) begin
            cnt   <= DIV_TOP;
            shreg <= shreg >> 1;
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= par;
          if (cnt == '0) begin
            state <= STOP;
            cnt   <= DIV_TOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (cnt == '0) begin
            if (pop) begin
              state <= START;
              cnt   <= DIV_TOP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      rdata    <= '0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (clr_req)
        overflow <= 1'b0;
      if (rd_req)
        rdata <= {27'b0, overflow, busy,
                  full, empty, ~full};
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: line-level frame decoder vs
// a queue of accepted bytes, plus directed timing and status checks.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;
  logic        overflow;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLK_DIV(DIV),
    .FIFO_LOG(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata),
    .mem_addr(mem_addr),
    .rdata(rdata),
    .tx(tx),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int rst_gen = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Line image of one frame, index 0 = first bit on the wire
  function automatic logic [NBITS-1:0] frame_bits(logic [7:0] b);
    logic [NBITS-1:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {1'b1, b, 1'b0};
`endif
    return f;
  endfunction

  initial begin : monitor
    logic [NBITS-1:0] seen;
    logic [7:0] want;
    logic ok;
    int g;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        g = rst_gen;
        ok = 1'b1;
        seen = '0;
        start_q.push_back(cyc);
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (i % DIV == 0) seen[i / DIV] = tx;
          else if (tx !== seen[i / DIV]) ok = 1'b0;
        end
        if (g == rst_gen) begin
          frames++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame got %h want none",
                     seen);
          end else begin
            want = exp_q.pop_front();
            check("frame", 32'({ok, seen}),
                  32'({1'b1, frame_bits(want)}));
          end
        end
      end
    end
  end

  task automatic bus(logic w, logic [3:0] m,
                     logic [31:0] a, logic [31:0] d);
    mem_valid = 1'b1;
    mem_write = w;
    mem_wmask = m;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_write = 1'b0;
    mem_wmask = '0;
  endtask

  task automatic push(logic [7:0] b);
    logic [31:0] d;
    logic [3:0] m;
    d = $urandom;
    d[7:0] = b;
    m = 4'($urandom);
    m[0] = 1'b1;
    bus(1'b1, m, BASE, d);
  endtask

  task automatic read_status(output logic [31:0] r);
    bus(1'b0, 4'($urandom), BASE + 32'd4, $urandom);
    r = rdata;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(n >= 3000), 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 32'd0);
  endtask

  task automatic junk_op();
    logic [31:0] d;
    d = $urandom;
    case ($urandom_range(0, 3))
      0: bus(1'b1, {3'($urandom), 1'b0}, BASE, d);
      1: bus(1'b1, 4'hF, BASE + 32'd8, d);
      2: bus(1'b0, 4'hF, BASE, d);
      default: begin
        d[0] = 1'b0;
        bus(1'b1, 4'hF, BASE + 32'd4, d);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0] b;
    int f0;
    int gap;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    read_status(r);
    check("status_idle", r, 32'h3);
    @(negedge clk);
    check("rdata_hold", rdata, 32'h3);

    exp_q.push_back(8'h55);
    push(8'h55);
    check("busy_after_push", busy, 1);
    @(negedge clk);
    check("tx_latency_e1", tx, 1);
    @(negedge clk);
    check("tx_latency_e2", tx, 0);
    repeat (FRAME - 2) @(negedge clk);
    check("busy_end_frame", busy, 1);
    @(negedge clk);
    check("busy_fall", busy, 0);
    wait_idle("single");

    start_q.delete();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    push(8'h41);
    push(8'h42);
    wait_idle("b2b");
    check("b2b_frames", start_q.size(), 2);
    gap = (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1;
    check("b2b_gap", gap, FRAME);

    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    push(8'h07);
    push(8'h03);
    wait_idle("parity_pair");

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 9) exp_q.push_back(b);
      push(b);
    end
    check("overflow_set", overflow, 1);
    read_status(r);
    check("status_full", r, 32'h1C);
    bus(1'b1, 4'hF, BASE + 32'd4, 32'h2);
    check("overflow_noclr", overflow, 1);
    bus(1'b1, 4'h1, BASE + 32'd4, 32'h1);
    check("overflow_clr", overflow, 0);
    wait_idle("overflow");

    repeat (8) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
        repeat ($urandom_range(0, 3)) junk_op();
      end
      wait_idle("random");
    end
    check("overflow_random", overflow, 0);

    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'hA5 : 8'($urandom);
      exp_q.push_back(b);
      push(b);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    rst_gen++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    read_status(r);
    check("midrst_status", r, 32'h3);
    f0 = frames;
    repeat (100) @(negedge clk);
    check("midrst_no_frames", frames, f0);
    check("midrst_tx_idle", tx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
